vec_cache_tag_dirty_ctrl: RTL

- Sequencer/arbiter in front of the dual-port tag/dirty array.
- Maps a lookup-update requester onto array port 0 and a refill-write requester onto array port 1, with swap semantics: a write returns the old entry one cycle later.
- Contains a flush engine that sweeps every entry via port 0, clears it, and emits non-zero old entries as evictions through a small buffer.

---
 rtl/vec_cache_tag_dirty_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vec_cache_tag_dirty_ctrl.sv
// rtl/vec_cache_tag_dirty_ctrl.sv - tag/dirty array port sequencer with flush sweep and eviction buffer
// Port 0 serves lookup-updates or the flush sweep; port 1 serves refills.
module vec_cache_tag_dirty_ctrl #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 4,
   parameter int EVICT_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [ADDR_WIDTH-1:0] upd_addr,
   input  logic [DATA_WIDTH-1:0] upd_data,
   output logic                  upd_rsp_valid,
   output logic [DATA_WIDTH-1:0] upd_rsp_data,
   input  logic                  fill_valid,
   output logic                  fill_ready,
   input  logic [ADDR_WIDTH-1:0] fill_addr,
   input  logic [DATA_WIDTH-1:0] fill_data,
   input  logic                  flush_start,
   output logic                  flush_busy,
   output logic                  flush_done,
   output logic                  evict_valid,
   input  logic                  evict_ready,
   output logic [ADDR_WIDTH-1:0] evict_addr,
   output logic [DATA_WIDTH-1:0] evict_data,
   output logic                  arr_wr_en_0,
   output logic [ADDR_WIDTH-1:0] arr_addr_0,
   output logic [DATA_WIDTH-1:0] arr_wr_data_0,
   input  logic [DATA_WIDTH-1:0] arr_rd_data_0,
   output logic                  arr_wr_en_1,
   output logic [ADDR_WIDTH-1:0] arr_addr_1,
   output logic [DATA_WIDTH-1:0] arr_wr_data_1,
   input  logic [DATA_WIDTH-1:0] arr_rd_data_1
);
   localparam int PTR_W = (EVICT_DEPTH > 1) ? $clog2(EVICT_DEPTH) : 1;
   localparam int CNT_W = $clog2(EVICT_DEPTH + 1);
   localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] sweep_ptr;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic                  inflight;
   logic                  busy_q;
   logic                  done_q;
   logic                  rsp_valid_q;
   logic [CNT_W-1:0]      fifo_count;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [ENT_W-1:0]      fifo_mem [EVICT_DEPTH];

   logic credit_ok;
   logic sweep_issue;
   logic upd_acc;
   logic fill_acc;
   logic p0_wr;
   logic collide;
   logic push;
   logic pop;
   logic unused_rd1;

   // An in-flight sweep read reserves a FIFO slot so its capture can never overflow.
   assign credit_ok   = (32'(fifo_count) + 32'(inflight)) < 32'(EVICT_DEPTH);
   assign sweep_issue = (state == SWEEP) && credit_ok;
   assign upd_ready   = !rst && (state == IDLE);
   assign upd_acc     = upd_valid && upd_ready;
   assign p0_wr       = upd_acc || sweep_issue;

   assign arr_wr_en_0   = p0_wr;
   assign arr_addr_0    = (state == SWEEP) ? sweep_ptr : (upd_acc ? upd_addr : '0);
   assign arr_wr_data_0 = upd_acc ? upd_data : '0;

   assign collide       = p0_wr && (fill_addr == arr_addr_0);
   assign fill_ready    = !rst && !collide;
   assign fill_acc      = fill_valid && fill_ready;
   assign arr_wr_en_1   = fill_acc;
   assign arr_addr_1    = fill_acc ? fill_addr : '0;
   assign arr_wr_data_1 = fill_acc ? fill_data : '0;
   assign unused_rd1    = ^arr_rd_data_1;

   assign upd_rsp_valid = rsp_valid_q;
   assign upd_rsp_data  = rsp_valid_q ? arr_rd_data_0 : '0;
   assign flush_busy    = busy_q;
   assign flush_done    = done_q;

   assign push        = inflight && (arr_rd_data_0 != '0);
   assign evict_valid = (fifo_count != '0);
   assign pop         = evict_valid && evict_ready;
   assign {evict_addr, evict_data} = evict_valid ? fifo_mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sweep_ptr   <= '0;
         cap_addr    <= '0;
         inflight    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= upd_acc;
         inflight    <= sweep_issue;
         done_q      <= 1'b0;
         if (sweep_issue) begin
            cap_addr <= sweep_ptr;
            if (sweep_ptr != LAST_IDX)
               sweep_ptr <= sweep_ptr + ADDR_WIDTH'(1);
         end
         case (state)
            IDLE: begin
               if (flush_start) begin
                  state     <= SWEEP;
                  sweep_ptr <= '0;
                  busy_q    <= 1'b1;
               end
            end
            SWEEP: begin
               if (sweep_issue && (sweep_ptr == LAST_IDX))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (!inflight && (fifo_count == '0)) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_count <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PTR_W'(EVICT_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= (rd_ptr == PTR_W'(EVICT_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {cap_addr, arr_rd_data_0};
   end
endmodule
